// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
//   Streaming front-end and result collector for fir_filter. Samples enter
//   over a valid/ready handshake and are shifted into a TAPS-deep delay line
//   (input_buffer, index 0 = newest). Once the line is full, every accepted
//   sample launches one filter run: start_fir pulses for a cycle, the block
//   waits for fir_done, then presents fir_output on a valid/ready output.
//   A watchdog aborts runs that never complete and sets a sticky timeout_err.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   in_sample/valid/ready : sample input handshake
//   flush                 : clear line, fill count and timeout_err (IDLE only)
//   input_buffer          : delay line driving the filter
//   start_fir             : one-cycle run start pulse
//   fir_output, fir_done  : filter result and its one-cycle strobe
//   out_sample/valid/ready: result output handshake
//   timeout_err           : sticky watchdog abort flag
//   fill_count            : valid entries in the line, saturating at TAPS
module fir_sample_feeder #(
  parameter int DATA_WIDTH = 12,
  parameter int TAPS       = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic signed [DATA_WIDTH-1:0]         in_sample,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 flush,
  output logic [0:TAPS-1][DATA_WIDTH-1:0]      input_buffer,
  output logic                                 start_fir,
  input  logic signed [DATA_WIDTH-1:0]         fir_output,
  input  logic                                 fir_done,
  output logic signed [DATA_WIDTH-1:0]         out_sample,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 timeout_err,
  output logic [$clog2(TAPS):0]                fill_count
);

  localparam int CW  = $clog2(TAPS) + 1;
  localparam int WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t         state, state_nxt;
  logic [WDW-1:0] wd;
  logic [CW-1:0]  fill_inc;
  logic           do_accept, do_flush, do_capture, do_abort;

  // Handshake outputs depend only on registered state (plus reset), so there
  // is no combinational path from in_valid/out_ready back to in_ready.
  assign in_ready  = (state == S_IDLE) && !out_valid && !reset;
  assign start_fir = (state == S_START);
  assign fill_inc  = (fill_count == CW'(TAPS)) ? CW'(TAPS) : fill_count + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_accept  = 1'b0;
    do_flush   = 1'b0;
    do_capture = 1'b0;
    do_abort   = 1'b0;
    case (state)
      S_IDLE: begin
        // flush wins over a same-cycle sample
        if (flush) begin
          do_flush = 1'b1;
        end else if (in_valid && in_ready) begin
          do_accept = 1'b1;
          // a run fires only once the line holds TAPS real samples
          if (fill_inc == CW'(TAPS)) state_nxt = S_START;
        end
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (fir_done) begin
          do_capture = 1'b1;
          state_nxt  = S_IDLE;
        end else if (wd == WDW'(TIMEOUT - 1)) begin
          do_abort  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      input_buffer <= '0;
      fill_count   <= '0;
      out_sample   <= '0;
      out_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      wd           <= '0;
    end else begin
      if (do_flush) begin
        input_buffer <= '0;
        fill_count   <= '0;
        timeout_err  <= 1'b0;
      end else if (do_accept) begin
        input_buffer[0] <= in_sample;
        for (int i = 1; i < TAPS; i++) input_buffer[i] <= input_buffer[i-1];
        fill_count <= fill_inc;
      end

      if (state == S_START)                wd <= '0;
      else if (state == S_WAIT && !fir_done) wd <= wd + WDW'(1);

      if (do_abort) timeout_err <= 1'b1;

      // capture only happens in WAIT, where out_valid is already low
      if (do_capture) begin
        out_sample <= fir_output;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: a filter stub answers start_fir with a random
// result TAPS+1 cycles later (or never, in timeout mode); expected results go
// into a scoreboard queue and a negedge monitor pops them on each output
// handshake. A queue of accepted samples stands in for the delay line.
module tb_fir_sample_feeder;
  localparam int DW       = 12;
  localparam int TAPS     = 16;
  localparam int TIMEOUT  = 64;
  localparam int DONE_DLY = TAPS + 1;

  logic                      clk, reset;
  logic [DW-1:0]             in_sample;
  logic                      in_valid, in_ready, flush;
  logic [0:TAPS-1][DW-1:0]   input_buffer;
  logic                      start_fir;
  logic [DW-1:0]             fir_output;
  logic                      fir_done;
  logic [DW-1:0]             out_sample;
  logic                      out_valid, out_ready, timeout_err;
  logic [$clog2(TAPS):0]     fill_count;

  fir_sample_feeder #(.DATA_WIDTH(DW), .TAPS(TAPS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .input_buffer(input_buffer),
    .start_fir(start_fir), .fir_output(fir_output), .fir_done(fir_done),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
    .timeout_err(timeout_err), .fill_count(fill_count)
  );

  int checks = 0, failures = 0, cyc = 0;
  logic [DW-1:0] hist[$];   // accepted samples, newest first, at most TAPS
  logic [DW-1:0] sb[$];     // expected results
  bit  stub_respond = 1, stub_fixed = 0, stub_pend = 0, rand_or = 0, flush_honour = 0;
  int  stub_cnt = 0;
  logic [DW-1:0] stub_val;
  int  acc_cyc = -100, exp_start_cyc = -100, start_cyc = -100;
  bit  ov_q = 0, te_q = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_buf(input string nm);
    logic [0:TAPS-1][DW-1:0] eb;
    eb = '0;
    for (int i = 0; i < hist.size(); i++) eb[i] = hist[i];
    checks++;
    if (input_buffer !== eb) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, input_buffer, eb, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [DW-1:0] s);
    int k = 0;
    while (!in_ready && k < 300) begin tick(1); k++; end
    if (k == 300) chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; in_sample = s;
    tick(1);
    in_valid = 1'b0; in_sample = DW'($urandom);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (!(sb.size() == 0 && in_ready) && k < 500) begin tick(1); k++; end
    if (k == 500) chk("drain", sb.size(), 0);
  endtask

  // filter stub
  always @(posedge clk) begin
    #1;
    fir_done = 1'b0;
    fir_output = DW'($urandom);
    if (start_fir) begin
      if (stub_respond) begin
        stub_pend = 1; stub_cnt = DONE_DLY;
        stub_val = stub_fixed ? DW'(12'h123) : DW'($urandom);
        sb.push_back(stub_val);
      end
    end else if (stub_pend) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        fir_done = 1'b1; fir_output = stub_val; stub_pend = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  end

  // monitor and reference model
  always @(negedge clk) begin
    if (reset) begin
      hist.delete();
    end else begin
      chk("fill_count", fill_count, hist.size());
      chk_buf("line");
      chk("start_fir", start_fir, cyc == exp_start_cyc);
      if (start_fir) start_cyc = cyc;
      if (out_valid && !ov_q) chk("latency", cyc - acc_cyc, TAPS + 3);
      if (timeout_err && !te_q) chk("timeout_delay", cyc - start_cyc, TIMEOUT + 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", out_valid, 0);
        else chk("out_sample", out_sample, sb.pop_front());
      end
      if (flush && flush_honour) begin
        hist.delete();
      end else if (in_valid && in_ready) begin
        hist.push_front(in_sample);
        if (hist.size() > TAPS) void'(hist.pop_back());
        acc_cyc = cyc;
        if (hist.size() == TAPS) exp_start_cyc = cyc + 1;
      end
    end
    ov_q = out_valid;
    te_q = timeout_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    reset = 1; in_valid = 0; in_sample = '0; flush = 0; out_ready = 1;
    fir_done = 0; fir_output = '0;
    tick(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_start", start_fir, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_fill", fill_count, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_buf", input_buffer, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 0; #1;
    chk("in_ready_after_rst", in_ready, 1);

    // priming
    for (int i = 1; i <= 15; i++) send(DW'(i));
    tick(2);
    chk("prime_fill", fill_count, 15);
    chk("prime_buf0", input_buffer[0], 15);
    chk("prime_buf14", input_buffer[14], 1);

    // first run with fixed result and backpressure
    stub_fixed = 1; out_ready = 0;
    send(DW'(16));
    chk("run1_start", start_fir, 1);
    chk("run1_buf0", input_buffer[0], 16);
    chk("run1_buf15", input_buffer[15], 1);
    k = 0;
    while (!out_valid && k < 40) begin chk("busy_in_ready", in_ready, 0); tick(1); k++; end
    chk("run1_out_valid", out_valid, 1);
    chk("run1_out_sample", out_sample, 12'h123);
    stub_fixed = 0;
    repeat (10) begin
      tick(1);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sample", out_sample, 12'h123);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    tick(1);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);

    // random runs with random backpressure
    rand_or = 1;
    repeat (12) send(DW'($urandom));
    rand_or = 0; out_ready = 1;
    wait_drain();

    // timeout
    stub_respond = 0;
    send(DW'($urandom));
    k = 0;
    while (!timeout_err && k < 200) begin tick(1); k++; end
    chk("timeout_err", timeout_err, 1);
    chk("timeout_no_out", out_valid, 0);
    chk("timeout_idle", in_ready, 1);
    stub_respond = 1;
    send(DW'($urandom));
    chk("after_timeout_start", start_fir, 1);
    wait_drain();
    chk("timeout_sticky", timeout_err, 1);
    flush = 1; flush_honour = 1;
    tick(1);
    flush = 0; flush_honour = 0;
    chk("flush_timeout", timeout_err, 0);
    chk("flush_fill", fill_count, 0);

    // flush priority over a sample with a full line
    for (int i = 0; i < TAPS; i++) send(DW'($urandom));
    wait_drain();
    chk("full_fill", fill_count, TAPS);
    flush = 1; flush_honour = 1; in_valid = 1; in_sample = DW'(12'h7ff);
    tick(1);
    flush = 0; flush_honour = 0; in_valid = 0;
    chk("flushprio_fill", fill_count, 0);
    chk("flushprio_buf", input_buffer, 0);
    chk("flushprio_nostart", start_fir, 0);

    // flush during WAIT is ignored
    for (int i = 0; i < TAPS; i++) send(DW'($urandom));
    tick(3);
    flush = 1;
    tick(1);
    flush = 0;
    wait_drain();
    chk("waitflush_fill", fill_count, TAPS);
    chk_buf("waitflush_buf");

    // reset five cycles into WAIT
    send(DW'($urandom));
    tick(6);
    reset = 1;
    if (sb.size() > 0) void'(sb.pop_back());
    tick(1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_start", start_fir, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    chk("mid_rst_fill", fill_count, 0);
    chk("mid_rst_out_sample", out_sample, 0);
    chk("mid_rst_buf", input_buffer, 0);
    reset = 0; #1;
    chk("mid_rst_in_ready", in_ready, 1);
    tick(25);
    chk("late_done_ignored", out_valid, 0);
    chk("late_done_fill", fill_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Streaming front-end and result collector for `fir_filter`. It accepts samples one at a time over a valid/ready input and maintains the TAPS-deep delay line that drives `fir_filter.input_buffer`. Once the line is full, every accepted sample triggers one filter run: the block pulses `start_fir`, waits for `fir_done`, and returns `fir_output` on a valid/ready output. A watchdog aborts runs that never complete.

## Interface
- `DATA_WIDTH`, 12: sample and result width, signed.
- `TAPS`, 16: delay-line depth; must equal `fir_filter.TAPS`.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before abort; must be > TAPS+1.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_sample` in DATA_WIDTH: signed input sample.
- `in_valid` in 1: `in_sample` is valid.
- `in_ready` out 1: the block accepts a sample this cycle.
- `flush` in 1: clear the delay line, fill count and `timeout_err`.
- `input_buffer` out DATA_WIDTH x [0:TAPS-1]: delay line; index 0 is the newest sample. Connects to the filter.
- `start_fir` out 1: one-cycle start pulse to the filter.
- `fir_output` in DATA_WIDTH: filter result.
- `fir_done` in 1: filter result valid (one-cycle pulse).
- `out_sample` out DATA_WIDTH: captured filter result.
- `out_valid` out 1: `out_sample` is valid.
- `out_ready` in 1: downstream accepts `out_sample`.
- `timeout_err` out 1: sticky flag; a filter run timed out.
- `fill_count` out clog2(TAPS)+1: number of valid samples in the line, saturating at TAPS.

## Operation
- FSM states: IDLE, START, WAIT.
- `in_ready` is 1 when state is IDLE, `out_valid` is 0 and `reset` is 0. It is combinational from registered state only.
- **Accept** (`in_valid && in_ready`, IDLE):
  - Shift the line: `buf[0] <= in_sample`, `buf[i] <= buf[i-1]`; `buf[TAPS-1]` is discarded.
  - `fill_count` increments, saturating at TAPS.
  - If the post-increment count equals TAPS, go to START. Otherwise stay in IDLE (priming phase).
- **START**: `start_fir` = 1 for exactly this cycle. Clear the watchdog. Go to WAIT.
- **WAIT**:
  - The line is frozen (`in_ready` = 0).
  - On `fir_done`: `out_sample <= fir_output`, `out_valid <= 1`, go to IDLE.
  - Otherwise the watchdog increments. When the watchdog reaches TIMEOUT-1 without `fir_done`: set `timeout_err`, produce no output, go to IDLE.
- **Output**: `out_valid` clears on the cycle `out_ready` is 1. A new sample cannot be accepted until the result is taken. This guarantees `fir_done` never collides with a pending `out_valid`.
- **Flush**:
  - Honoured only in IDLE, and takes priority over a same-cycle `in_valid`.
  - Zeroes all line entries, `fill_count` and `timeout_err`.
  - A pending `out_valid` and `out_sample` are untouched.
  - `flush` in START or WAIT is ignored.
- `fir_done` outside WAIT is ignored.
- **Reset values**: state IDLE; all `input_buffer` entries 0; `start_fir` 0; `out_sample` 0; `out_valid` 0; `timeout_err` 0; `fill_count` 0; watchdog 0.
- **Reset mid-run** (START or WAIT): immediate return to IDLE with all values above. `fir_filter` shares `reset`, so its run aborts too.

## Timing
- Accept at edge E0 leads to START in the following cycle: `start_fir` is high in the cycle after E0.
- With `fir_filter`, `fir_done` arrives TAPS+1 cycles after the `start_fir` cycle.
- `out_valid` rises the cycle after `fir_done`.
- End-to-end latency, from accept edge to `out_valid`: TAPS+3 cycles (19 at TAPS=16).
- Maximum throughput: one sample per TAPS+4 cycles with `out_ready` held high.
- Timeout: the abort edge occurs TIMEOUT cycles after entering WAIT; `timeout_err` is visible the next cycle.
- `input_buffer` is stable from the START cycle until `fir_done` is consumed.

## Test plan
- **Priming**: reset, then feed samples 1..15 with `out_ready`=1.
  - `start_fir` never pulses; `fill_count` = 15; `buf[0]`=15, `buf[14]`=1.
  - The 16th sample (16) gives `start_fir` exactly one cycle after accept, with `buf[0]`=16 and `buf[15]`=1.
- **Result capture**: filter stub asserts `fir_done` 17 cycles after start with `fir_output` = 12'sh123.
  - `out_sample` = 12'sh123 and `out_valid` = 1 exactly 19 cycles after the accept edge.
  - `in_ready` = 0 throughout.
- **Backpressure**: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `out_valid` and `out_sample` are held; `in_ready` stays 0.
  - Raising `out_ready` clears `out_valid` next cycle and `in_ready` returns to 1.
- **Timeout**: stub never returns `fir_done`.
  - `timeout_err` = 1 after 64 WAIT cycles; state returns to IDLE; no `out_valid`.
  - The next sample starts a new run.
  - A `flush` in IDLE clears `timeout_err` and `fill_count` to 0.
- **Flush priority**: assert `flush` and `in_valid` together in IDLE with `fill_count`=16.
  - The sample is not shifted in; all entries are 0 and `fill_count`=0 afterwards.
  - `flush` asserted during WAIT has no effect.
- **Reset mid-WAIT**: assert `reset` 5 cycles into WAIT.
  - The next cycle shows every output at its reset value and `in_ready`=1 after deassert.
  - A late stub `fir_done` is ignored.
